seq_stage23_fifo: RTL and testbench
===================================

# seq_stage23_fifo

Parametrised synchronous FIFO built on an inferred memory array with enabled write port, pointer registers and occupancy counter; the general-purpose buffering successor to the fixed-size register/memory stages. Sits between any valid/ready producer and consumer inside one clock domain. Also tracks an occupancy high-watermark and carries optional simulation tracing that exercises display lowering.

## Interface
- WIDTH, 8, data bits per entry (≥1)
- DEPTH, 16, entries; power of two, ≥2
- AFULL_LVL, DEPTH-2, count at or above which almost_full asserts (1..DEPTH)
- CW (localparam), $clog2(DEPTH)+1, width of count outputs
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous discard of all contents
- in_valid  input  1  producer offers in_data
- in_ready  output  1  FIFO can accept
- in_data  input  WIDTH  write data
- out_valid  output  1  out_data holds head entry
- out_ready  input  1  consumer takes head
- out_data  output  WIDTH  head entry
- count  output  CW  current occupancy 0..DEPTH
- almost_full  output  1  count ≥ AFULL_LVL
- max_count  output  CW  highest count since last rst/flush

## Operation
- Storage: mem[0:DEPTH-1] of WIDTH; wr_ptr, rd_ptr each $clog2(DEPTH) bits, wrap modulo DEPTH naturally; count held as separate register.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH) & !flush. out_valid = (count != 0) & !flush.
- out_data = mem[rd_ptr] (asynchronous read); value when out_valid=0 is don't-care.
- On push: mem[wr_ptr] <= in_data, wr_ptr+1. On pop: rd_ptr+1.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full: no push even if pop same cycle (no bypass on full). Empty: no pop; push into empty is not visible until next cycle.
- max_count <= max(max_count, next count) every cycle.
- almost_full is combinational from count.
- flush (rst not asserted): wr_ptr, rd_ptr, count, max_count <= 0; in_ready/out_valid forced 0 that cycle, so no handshake completes; mem contents untouched.
- rst: same as flush plus priority over flush; mem not reset.
- Priority: rst > flush > push/pop.

## Timing
- Reset values: count=0, max_count=0, out_valid=0, in_ready=1 (in cycle after rst released with flush low), almost_full=0 (AFULL_LVL≥1).
- Write-to-read latency: push accepted at edge N → out_valid=1 and out_data valid after edge N (1 cycle).
- Pop at edge N → next entry presented after edge N; back-to-back pops at full rate.
- Sustained 1 push + 1 pop per cycle at any count 1..DEPTH−1.
- Full recovery: pop at edge N on full → in_ready=1 after edge N.
- rst or flush mid-stream: data in flight that cycle is discarded; next cycle FIFO is empty.

## Configuration
- SEQ_FIFO_TRACE_EN defined: inside the sequential process, $display("push d=%0d cnt=%0d", in_data, count) on each push and $display("pop d=%0d cnt=%0d", out_data, count) on each pop, both guarded by !rst & !flush; count printed is pre-update value.
- Not defined: no system tasks emitted; datapath and all outputs bit-identical.

## Structure
- Package seq_fifo_pkg: default constants SEQ_FIFO_WIDTH_DEF=8, SEQ_FIFO_DEPTH_DEF=16; elaboration check helper function is_pow2(int).
- Sub-module seq_fifo_ptr: parametrised pointer register (width, inc enable, clear) instantiated twice for wr_ptr and rd_ptr.
- Top holds mem, count, max_count, handshake logic and trace block.

## Test plan
- DEPTH=4, WIDTH=8: rst 2 cycles → count=0, out_valid=0, in_ready=1, max_count=0.
- Push 0x11,0x22,0x33,0x44 with out_ready=0 → count=4, in_ready=0, almost_full=1 from count=2; fifth push 0x55 held, not stored.
- Then out_ready=1 four cycles → out_data 0x11,0x22,0x33,0x44 in order; count=0; max_count stays 4.
- Simultaneous push/pop at count=2 for 8 cycles, data 0..7 → count stays 2, outputs in push order, pointers wrap twice without loss.
- Full with in_valid=1 and out_ready=1 → one pop, no push that cycle; next cycle push accepted, count back to 4.
- At count=3 assert flush with in_valid=1,out_ready=1 → no handshake, next cycle count=0, max_count=0, out_valid=0; rst mid-stream gives same result.

Source files
------------

// File: rtl/seq_fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : seq_fifo_pkg
// Purpose  : Shared constants, handshake-operation encoding and elaboration
//            helpers for the seq_stage23_fifo buffering block.
// Contents : SEQ_FIFO_WIDTH_DEF, SEQ_FIFO_DEPTH_DEF, op_e, is_pow2()
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package seq_fifo_pkg;

  localparam int SEQ_FIFO_WIDTH_DEF = 8;
  localparam int SEQ_FIFO_DEPTH_DEF = 16;

  // Encoding of the {push, pop} pair completed in one cycle.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  // True when v is a positive power of two.
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage : seq_fifo_pkg
`default_nettype wire

// File: rtl/seq_fifo_ptr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : seq_fifo_ptr
// Purpose  : Wrapping pointer register for the FIFO storage array. Wraps
//            modulo 2**PTR_W naturally by overflow.
// Ports    : clk   - clock
//            rst   - synchronous active-high reset
//            clear - synchronous clear (flush)
//            inc   - advance pointer by one
//            ptr   - current pointer value
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module seq_fifo_ptr #(
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule : seq_fifo_ptr
`default_nettype wire

// File: rtl/seq_stage23_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : seq_stage23_fifo
// Purpose  : Parametrised single-clock FIFO with valid/ready handshakes on
//            both sides, occupancy count, almost-full flag and occupancy
//            high-watermark.
// Ports    : clk, rst (sync, active-high), flush (sync discard)
//            in_valid / in_ready / in_data    - producer side
//            out_valid / out_ready / out_data - consumer side
//            count       - occupancy 0..DEPTH
//            almost_full - count >= AFULL_LVL
//            max_count   - highest count since last rst/flush
// Config   : define SEQ_FIFO_TRACE_EN to print push/pop trace messages in
//            simulation; undefined, no system tasks are emitted.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module seq_stage23_fifo
  import seq_fifo_pkg::*;
#(
  parameter int WIDTH     = SEQ_FIFO_WIDTH_DEF,
  parameter int DEPTH     = SEQ_FIFO_DEPTH_DEF,
  parameter int AFULL_LVL = DEPTH - 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic [CW-1:0]    max_count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  generate
    if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_depth_chk
      $error("seq_stage23_fifo: DEPTH must be a power of two >= 2");
    end
    if ((AFULL_LVL < 1) || (AFULL_LVL > DEPTH)) begin : g_afull_chk
      $error("seq_stage23_fifo: AFULL_LVL must be within 1..DEPTH");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count_nxt;
  op_e              op;

  // Flush blocks both handshakes so nothing is accepted or consumed in the
  // cycle whose state is being discarded. Full never accepts, even with a
  // simultaneous pop: there is no full-bypass path.
  assign in_ready    = (count != DEPTH_C) & ~flush;
  assign out_valid   = (count != '0) & ~flush;
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign out_data    = mem[rd_ptr];
  assign almost_full = (count >= AFULL_C);

  always_comb begin
    op        = op_e'({push, pop});
    count_nxt = count;
    case (op)
      OP_PUSH: count_nxt = count + CW'(1);
      OP_POP:  count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  seq_fifo_ptr #(.PTR_W(AW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  seq_fifo_ptr #(.PTR_W(AW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Storage is never reset; only the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count     <= '0;
      max_count <= '0;
    end else begin
      count <= count_nxt;
      if (count_nxt > max_count) begin
        max_count <= count_nxt;
      end
    end
`ifdef SEQ_FIFO_TRACE_EN
    if (!rst && !flush) begin
      if (push) begin
        $display("push d=%0d cnt=%0d", in_data, count);
      end
      if (pop) begin
        $display("pop d=%0d cnt=%0d", out_data, count);
      end
    end
`endif
  end

endmodule : seq_stage23_fifo
`default_nettype wire

// File: tb/tb_seq_stage23_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_seq_stage23_fifo
// Purpose  : Self-checking bench for seq_stage23_fifo (DEPTH=4, WIDTH=8)
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_seq_stage23_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AFULL = DEPTH - 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic [CW-1:0]    max_count;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue plus high-watermark.
  logic [WIDTH-1:0] model_q[$];
  int               model_max;

  seq_stage23_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full),
    .max_count   (max_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle against the
  // model, then advance the model at the active edge.
  task automatic cycle(input bit r, input bit f, input bit iv,
                       input logic [WIDTH-1:0] d, input bit ordy, input bit chk);
    bit exp_ir, exp_ov, do_push, do_pop;
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    exp_ir  = (model_q.size() != DEPTH) && !f;
    exp_ov  = (model_q.size() != 0) && !f;
    do_push = iv && exp_ir;
    do_pop  = ordy && exp_ov;
    if (chk) begin
      check("count", 32'(count), 32'(model_q.size()));
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("almost_full", 32'(almost_full), 32'(model_q.size() >= AFULL));
      check("max_count", 32'(max_count), 32'(model_max));
      if (exp_ov) check("out_data", 32'(out_data), 32'(model_q[0]));
    end
    @(posedge clk);
    if (r || f) begin
      model_q.delete();
      model_max = 0;
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
      if (model_q.size() > model_max) model_max = model_q.size();
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_max = 0;
    #1;

    // Reset for two cycles; outputs are unknown until the first edge.
    cycle(1, 0, 0, 8'h00, 0, 0);
    cycle(1, 0, 0, 8'h00, 0, 1);
    cycle(0, 0, 0, 8'h00, 0, 1);

    // Fill to full with consumer stalled, then a rejected fifth push.
    cycle(0, 0, 1, 8'h11, 0, 1);
    cycle(0, 0, 1, 8'h22, 0, 1);
    cycle(0, 0, 1, 8'h33, 0, 1);
    cycle(0, 0, 1, 8'h44, 0, 1);
    cycle(0, 0, 1, 8'h55, 0, 1);
    cycle(0, 0, 0, 8'h00, 0, 1);

    // Drain in order.
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1, 1);
    cycle(0, 0, 0, 8'h00, 0, 1);

    // Prime to count=2, then sustained push+pop with wrapping pointers.
    cycle(0, 0, 1, 8'hA0, 0, 1);
    cycle(0, 0, 1, 8'hA1, 0, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 8'(i), 1, 1);
    cycle(0, 0, 0, 8'h00, 1, 1);
    cycle(0, 0, 0, 8'h00, 1, 1);

    // Full with both handshakes offered: pop only, then the push lands.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'(8'hC0 + i), 0, 1);
    cycle(0, 0, 1, 8'hC4, 1, 1);
    cycle(0, 0, 1, 8'hC5, 0, 1);
    cycle(0, 0, 0, 8'h00, 0, 1);

    // Flush at count=3 with both sides active.
    cycle(0, 0, 0, 8'h00, 1, 1);
    cycle(0, 1, 1, 8'hD0, 1, 1);
    cycle(0, 0, 0, 8'h00, 0, 1);

    // Reset mid-stream at count=3.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'(8'hE0 + i), 0, 1);
    cycle(1, 0, 1, 8'hE3, 1, 1);
    cycle(0, 0, 0, 8'h00, 0, 1);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 29) == 0),
            bit'($urandom_range(0, 2) != 0), 8'($urandom),
            bit'($urandom_range(0, 2) != 0), 1);
    end
    cycle(0, 0, 0, 8'h00, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_stage23_fifo
`default_nettype wire
